// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned width);
        if (width > 32'd1) begin
            return $unsigned($clog2(width));
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder shared by every bit step of the serial adder.
module fa_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_sum_c,
    output logic o_carry_c
);

    assign o_sum_c   = i_x ^ i_y ^ i_ci;
    assign o_carry_c = (i_x & i_y) | (i_ci & (i_x ^ i_y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: accepts an operand pair, walks one full-adder
// cell over it LSB first, and returns the sum and carry-out over a handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_done_valid,
    input  logic             i_done_ready
);

    localparam int unsigned       IDX_W    = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             r_cout;
    logic             w_cout_nxt;
    logic             r_start_ready;
    logic             r_done_valid;
    logic             w_s;
    logic             w_c;

    fa_cell u_fa (
        .i_x      (r_a[0]),
        .i_y      (r_b[0]),
        .i_ci     (r_carry),
        .o_sum_c  (w_s),
        .o_carry_c(w_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update; subtraction is a + ~b + 1.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_cout_nxt  = r_cout;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start_valid) begin
                    w_a_nxt     = i_a;
                    w_b_nxt     = i_sub ? ~i_b : i_b;
                    w_carry_nxt = i_sub ? 1'b1 : i_cin;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_carry_nxt            = w_c;
                w_sum_nxt              = r_sum >> 1;
                w_sum_nxt[WIDTH-1]     = w_s;
                w_a_nxt                = r_a >> 1;
                w_b_nxt                = r_b >> 1;
                w_idx_nxt              = r_idx + IDX_W'(1);
                if (r_idx == IDX_LAST) begin
                    w_cout_nxt  = w_c;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_done_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so outputs stay flop-driven.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_sum         <= '0;
            r_idx         <= '0;
            r_carry       <= 1'b0;
            r_cout        <= 1'b0;
            r_start_ready <= 1'b1;
            r_done_valid  <= 1'b0;
        end else begin
            r_a           <= w_a_nxt;
            r_b           <= w_b_nxt;
            r_sum         <= w_sum_nxt;
            r_idx         <= w_idx_nxt;
            r_carry       <= w_carry_nxt;
            r_cout        <= w_cout_nxt;
            r_start_ready <= (w_state_nxt == ST_IDLE);
            r_done_valid  <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_done_valid  = r_done_valid;
    assign o_sum         = r_sum;
    assign o_cout        = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: directed cases on an 8-bit instance plus random traffic at widths 1, 8, 13.
module tb_serial_add_ctrl;

    localparam int unsigned N_RAND = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic sb);
        if (sb) begin
            return {a >= b, 8'(a - b)};
        end
        return 9'(a) + 9'(b) + 9'(ci);
    endfunction

    // Directed 8-bit instance
    logic       d_rst, d_sv, d_sr, d_dv, d_dr, d_ci, d_sb, d_co;
    logic [7:0] d_a, d_b, d_s;
    logic [8:0] d_q[$];

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .i_clk        (clk),
        .i_rst        (d_rst),
        .i_start_valid(d_sv),
        .o_start_ready(d_sr),
        .i_a          (d_a),
        .i_b          (d_b),
        .i_cin        (d_ci),
        .i_sub        (d_sb),
        .o_sum        (d_s),
        .o_cout       (d_co),
        .o_done_valid (d_dv),
        .i_done_ready (d_dr)
    );

    initial begin : d_monitor
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (d_dv && d_dr) begin
                if (d_q.size() == 0) begin
                    check_eq("dir_unexpected_result", 32'(d_dv), 32'd0);
                end else begin
                    e = d_q.pop_front();
                    check_eq("dir_result", 32'({d_co, d_s}), 32'(e));
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        int t;
        d_a  = a;
        d_b  = b;
        d_ci = ci;
        d_sb = sb;
        d_sv = 1'b1;
        t    = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!d_sr && t < 50);
        if (!d_sr) begin
            check_eq("dir_accept_timeout", 32'(d_sr), 32'd1);
        end
        @(posedge clk);
        d_q.push_back(model8(a, b, ci, sb));
        #1 d_sv = 1'b0;
    endtask

    task automatic run_lat(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
        int k;
        issue(a, b, ci, sb);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!d_dv && k < 40);
        check_eq("latency", 32'(k), 32'd8);
        @(posedge clk);
        #1;
        check_eq("dv_one_cycle", 32'(d_dv), 32'd0);
        check_eq("ready_back", 32'(d_sr), 32'd1);
    endtask

    // Random instances at several widths
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int unsigned W  = (g == 0) ? 1 : ((g == 1) ? 8 : 13);
        localparam int unsigned WE = W + 1;

        logic         rst, sv, sr, dv, dr, ci, sb, co;
        logic [W-1:0] a, b, s;
        logic [W:0]   q[$];
        logic         fin;

        serial_add_ctrl #(.WIDTH(W)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_start_valid(sv),
            .o_start_ready(sr),
            .i_a          (a),
            .i_b          (b),
            .i_cin        (ci),
            .i_sub        (sb),
            .o_sum        (s),
            .o_cout       (co),
            .o_done_valid (dv),
            .i_done_ready (dr)
        );

        initial begin : drv
            int       t;
            logic [W:0] e;
            fin = 1'b0;
            rst = 1'b1;
            sv  = 1'b0;
            a   = '0;
            b   = '0;
            ci  = 1'b0;
            sb  = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            for (int i = 0; i < N_RAND; i++) begin
                a  = W'($urandom);
                b  = W'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                sv = 1'b1;
                t  = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!sr && t < 200);
                if (!sr) begin
                    check_eq("rand_accept_timeout", 32'(sr), 32'd1);
                    break;
                end
                if (sb) begin
                    e = {a >= b, W'(a - b)};
                end else begin
                    e = WE'(a) + WE'(b) + WE'(ci);
                end
                @(posedge clk);
                q.push_back(e);
                #1 sv = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            t = 0;
            while (q.size() != 0 && t < 500) begin
                @(posedge clk);
                t++;
            end
            check_eq("rand_drain", 32'(q.size()), 32'd0);
            fin = 1'b1;
        end

        initial begin : mon
            logic [W:0] e;
            dr = 1'b0;
            forever begin
                @(negedge clk);
                dr = ($urandom_range(0, 3) != 0);
                if (dv && dr) begin
                    if (q.size() == 0) begin
                        check_eq("rand_unexpected_result", 32'(dv), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check_eq("rand_result", 32'({co, s}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t;
        int seen;
        logic [8:0] hold;
        d_rst = 1'b1;
        d_sv  = 1'b0;
        d_a   = '0;
        d_b   = '0;
        d_ci  = 1'b0;
        d_sb  = 1'b0;
        d_dr  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_start_ready", 32'(d_sr), 32'd1);
        check_eq("rst_done_valid", 32'(d_dv), 32'd0);
        check_eq("rst_sum_cout", 32'({d_co, d_s}), 32'd0);
        d_rst = 1'b0;

        run_lat(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_lat(8'hFF, 8'h01, 1'b0, 1'b0);
        run_lat(8'h00, 8'h00, 1'b1, 1'b0);
        run_lat(8'h10, 8'h01, 1'b1, 1'b1);
        run_lat(8'h01, 8'h02, 1'b0, 1'b1);

        // Backpressure with ghost start requests in RUN and DONE
        d_dr = 1'b0;
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        hold = model8(8'h33, 8'h44, 1'b0, 1'b0);
        d_a  = 8'hAA;
        d_b  = 8'h55;
        d_sv = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("run_start_ready", 32'(d_sr), 32'd0);
        end
        d_sv = 1'b0;
        t = 0;
        while (!d_dv && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            d_sv = (i % 2 == 0);
            check_eq("hold_result", 32'({d_co, d_s}), 32'(hold));
            check_eq("hold_done_valid", 32'(d_dv), 32'd1);
            check_eq("hold_start_ready", 32'(d_sr), 32'd0);
            @(posedge clk);
            #1;
        end
        d_sv = 1'b0;
        d_dr = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_start_ready", 32'(d_sr), 32'd1);
        check_eq("release_done_valid", 32'(d_dv), 32'd0);
        run_lat(8'h01, 8'h01, 1'b0, 1'b0);

        // Reset during the third RUN cycle discards the operation
        issue(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 d_rst = 1'b1;
        @(posedge clk);
        #1 d_rst = 1'b0;
        d_q.delete();
        check_eq("abort_start_ready", 32'(d_sr), 32'd1);
        check_eq("abort_done_valid", 32'(d_dv), 32'd0);
        check_eq("abort_sum_cout", 32'({d_co, d_s}), 32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (d_dv) seen++;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        run_lat(8'h12, 8'h34, 1'b0, 1'b0);

        t = 0;
        while (!(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check_eq("rand_complete", 32'(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin), 32'd1);
        check_eq("dir_queue_empty", 32'(d_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller. It accepts a WIDTH-bit operand pair over a valid/ready handshake and sequences a single one-bit full-adder cell over the operands, LSB first, one bit per clock. A registered carry links the bit steps. The block returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between operand producers and result consumers wherever area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is 1 or more.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- start_valid  in  1  an operand pair is presented.
- start_ready  out  1  the block can accept operands; high only in IDLE.
- a  in  WIDTH  first operand, sampled at the start handshake.
- b  in  WIDTH  second operand, sampled at the start handshake.
- cin  in  1  carry-in, sampled at the start handshake; ignored when sub=1.
- sub  in  1  selects the operation: 0 computes a+b+cin, 1 computes a-b.
- sum  out  WIDTH  result; valid while done_valid is high.
- cout  out  1  final carry. For sub=1, cout=1 means no borrow (a>=b, unsigned).
- done_valid  out  1  the result is available.
- done_ready  in  1  the consumer accepts the result.

## Operation
- States: IDLE, RUN, DONE. Encoding is one-hot or binary; both are acceptable.
- IDLE
  - start_ready=1.
  - When start_valid&&start_ready at a clock edge: load shift register A with a, and B with b (or with ~b when sub=1).
  - Load the carry register with cin (or with 1 when sub=1).
  - Clear the bit index idx to 0 and go to RUN.
- RUN, each cycle:
  - The full-adder cell takes A[0], B[0] and carry, producing s and c.
  - carry<=c.
  - The result register shifts right with s inserted at the MSB. A and B shift right.
  - idx<=idx+1.
  - When idx==WIDTH-1: go to DONE and set cout<=c.
- DONE
  - done_valid=1. sum and cout are held stable.
  - When done_valid&&done_ready: go to IDLE.
- Arithmetic: results are modulo 2^WIDTH, and the carry-out is exported only through cout. For WIDTH=1, RUN lasts exactly one cycle.
- idx width is max(1, $clog2(WIDTH)).
- start_valid is ignored outside IDLE; the producer must keep it asserted until it is accepted. Inputs a, b, cin and sub are don't-care outside the accepting edge.
- Reset is synchronous, active-high and takes priority over everything else, including mid-RUN and mid-DONE.
- Reset state:
  - state=IDLE.
  - start_ready=1.
  - done_valid=0.
  - sum=0, cout=0.
  - All internal registers are 0.
- An operation interrupted by reset is discarded, and no done_valid pulse is produced for it.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from input to output.
- The start handshake accepts on edge E0, so start_ready drops in the cycle after E0.
- done_valid rises exactly WIDTH clock edges after E0. For WIDTH=8, it is first high after edge E0+8.
- If done_ready is already high, the block returns to IDLE on the next edge, and start_ready is high again WIDTH+1 edges after E0.
- Minimum issue interval is WIDTH+2 cycles for back-to-back operations:
  - the accept edge;
  - WIDTH RUN edges;
  - the done edge;
  - then the next accept.
- There is no overlap between operations: a new start is never accepted in DONE.
- done_ready low holds DONE indefinitely, and sum and cout stay unchanged.

## Structure
- Shared package serial_add_pkg:
  - state enum type (IDLE, RUN, DONE);
  - default WIDTH constant;
  - idx width function.
- One sub-module is natural: fa_cell, a purely combinational one-bit full adder (s, c from x, y, ci). It is instantiated once.
- The controller holds the FSM, the shift registers, the carry register and the idx counter.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0, done_ready held high -> sum=0x96 and cout=0. done_valid is high exactly 8 edges after the accept edge, for one cycle.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- sub=1 with a=0x10, b=0x01 -> sum=0x0F, cout=1. Then sub=1 with a=0x01, b=0x02 -> sum=0xFF, cout=0 (borrow).
- Backpressure: hold done_ready low for 5 cycles after done_valid rises, and pulse start_valid with new operands during RUN and DONE -> sum and cout stay stable, start_ready stays 0, and the new operands are not accepted. After done_ready goes high, IDLE is reached and the next start is accepted.
- Assert rst for one cycle on the 3rd RUN cycle -> on the next cycle, state=IDLE, start_ready=1, done_valid=0, sum=0, cout=0, and no done_valid pulse ever appears for the aborted operation. The following operation a=0x12, b=0x34 gives sum=0x46.
- Random regression: 1000 random (a, b, cin, sub) at WIDTH=1, 8 and 13, with random done_ready stalls -> sum and cout match the reference model, and every accepted operation yields exactly one result, in order.
